demux14_stream: RTL and testbench

//   1-to-4 stream demultiplexer: the distribution counterpart of the 4:1 mux.
//   - Accepts words on one valid/ready input and steers each word to one of four outputs.
//   - Destination comes from an explicit select or from an internal round-robin pointer.
//   - Each output has its own one-entry holding slot, so a stalled output blocks only words addressed to it.

---
 rtl/mux_pkg.sv | 20 ++
 rtl/demux_slot.sv | 44 ++++
 rtl/demux14_stream.sv | 68 ++++++
 tb/tb_demux14_stream.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared channel definitions for the 4:1 mux / 1:4 demux stream pair.
// Both blocks import this so that channel numbering stays consistent.
package mux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] ch_sel_t;

  localparam ch_sel_t CH0 = 2'd0;
  localparam ch_sel_t CH1 = 2'd1;
  localparam ch_sel_t CH2 = 2'd2;
  localparam ch_sel_t CH3 = 2'd3;

  // Round-robin successor; the natural 2-bit overflow gives the 3 -> 0 wrap.
  function automatic ch_sel_t next_ch(input ch_sel_t c);
    return c + ch_sel_t'(1);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot for a single demux output channel.
// It loads on accept, drains on ready, and supports drain+refill in one cycle.
module demux_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A load always wins: it either fills an empty slot or replaces the word
  // that is draining this same cycle. The top never loads a full, stalled slot.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/demux14_stream.sv
// 1-to-4 stream demultiplexer with explicit or round-robin steering.
// Each channel has its own slot, so a stalled consumer only blocks its own words.
module demux14_stream
  import mux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SEL_W-1:0]  in_select,
  input  logic              rr_mode,
  output logic [WIDTH-1:0]  out1,
  output logic [WIDTH-1:0]  out2,
  output logic [WIDTH-1:0]  out3,
  output logic [WIDTH-1:0]  out4,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready
);

  ch_sel_t                        rr_ptr_q, rr_ptr_d;
  ch_sel_t                        dest;
  logic                           accept;
  logic [NUM_CH-1:0]              load;
  logic [NUM_CH-1:0]              slot_vld;
  logic [NUM_CH-1:0][WIDTH-1:0]   slot_data;

  assign dest     = rr_mode ? rr_ptr_q : ch_sel_t'(in_select);
  // Independent of in_valid so a producer can observe readiness before committing.
  assign in_ready = !slot_vld[dest] || out_ready[dest];
  assign accept   = in_valid && in_ready;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && rr_mode) rr_ptr_d = next_ch(rr_ptr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= CH0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_slot
      assign load[k] = accept && (dest == ch_sel_t'(k));

      demux_slot #(.WIDTH(WIDTH)) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load[k]),
        .data_i  (in_data),
        .ready_i (out_ready[k]),
        .valid_o (slot_vld[k]),
        .data_o  (slot_data[k])
      );
    end
  endgenerate

  assign out_valid = slot_vld;
  assign out1      = slot_data[CH0];
  assign out2      = slot_data[CH1];
  assign out3      = slot_data[CH2];
  assign out4      = slot_data[CH3];

endmodule

// File: tb/tb_demux14_stream.sv
// Directed and random checks for demux14_stream against hand-computed values
// and a per-channel one-entry scoreboard.
module tb_demux14_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_select;
  logic       rr_mode;
  logic [3:0] out1, out2, out3, out4;
  logic [3:0] out_valid;
  logic [3:0] out_ready;

  int checks = 0;
  int errors = 0;

  // scoreboard state
  bit         mv [4];
  logic [3:0] md [4];
  logic [1:0] mptr;
  bit         pending;
  int         n_in, n_out;

  demux14_stream #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_select (in_select),
    .rr_mode   (rr_mode),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] get_out(input int ch);
    case (ch)
      0:       return out1;
      1:       return out2;
      2:       return out3;
      default: return out4;
    endcase
  endfunction

  // Offer one word, expect it accepted, then expect it alone on channel ch.
  task automatic send(input string tag, input logic [3:0] d, input logic [1:0] sel, input int ch);
    in_valid  = 1'b1;
    in_data   = d;
    in_select = sel;
    #1;
    chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, ".vld"}, 32'(out_valid), 32'(4'b0001 << ch));
    chk({tag, ".dat"}, 32'(get_out(ch)), 32'(d));
  endtask

  task automatic stress_cycle(input bit allow_in);
    logic [1:0] d;
    bit exp_rdy;
    if (!allow_in) begin
      in_valid = 1'b0;
    end else if (!pending) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 4'($urandom_range(0, 15));
      in_select = 2'($urandom_range(0, 3));
      rr_mode   = 1'($urandom_range(0, 1));
    end
    out_ready = allow_in ? 4'($urandom_range(0, 15)) : 4'b1111;
    #1;
    d = rr_mode ? mptr : in_select;
    exp_rdy = !mv[d] || out_ready[d];
    chk("stress.rdy", 32'(in_ready), 32'(exp_rdy));
    for (int k = 0; k < 4; k++) begin
      chk("stress.vld", 32'(out_valid[k]), 32'(mv[k]));
      if (mv[k] && out_ready[k]) begin
        chk("stress.dat", 32'(get_out(k)), 32'(md[k]));
        mv[k] = 1'b0;
        n_out++;
      end
    end
    if (in_valid && exp_rdy) begin
      mv[d] = 1'b1;
      md[d] = in_data;
      n_in++;
      if (rr_mode) mptr = mptr + 2'd1;
    end
    pending = in_valid && !exp_rdy;
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    in_select = 2'd0;
    rr_mode   = 1'b0;
    out_ready = 4'b1111;
    #2;
    chk("rst.vld", 32'(out_valid), 32'h0);
    chk("rst.out1", 32'(out1), 32'h0);
    chk("rst.rdy", 32'(in_ready), 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // explicit steering
    send("exp0", 4'b0001, 2'd0, 0);
    send("exp1", 4'b0011, 2'd1, 1);
    send("exp2", 4'b0111, 2'd2, 2);
    send("exp3", 4'b1111, 2'd3, 3);
    tick();
    chk("exp.idle", 32'(out_valid), 32'h0);

    // round robin, select ignored
    rr_mode = 1'b1;
    for (int i = 0; i < 8; i++) send("rr", 4'(i), 2'd3, i % 4);
    tick();

    // blocking isolation on channel 2
    rr_mode   = 1'b0;
    out_ready = 4'b1011;
    send("blk.fill", 4'hA, 2'd2, 2);
    in_valid  = 1'b1;
    in_data   = 4'h5;
    in_select = 2'd2;
    #1;
    chk("blk.stall", 32'(in_ready), 32'h0);
    tick();
    chk("blk.hold.vld", 32'(out_valid), 32'b0100);
    chk("blk.hold.dat", 32'(out3), 32'hA);
    in_data   = 4'h6;
    in_select = 2'd0;
    #1;
    chk("blk.other.rdy", 32'(in_ready), 32'h1);
    tick();
    chk("blk.other.vld", 32'(out_valid), 32'b0101);
    chk("blk.other.dat", 32'(out1), 32'h6);
    chk("blk.other.out3", 32'(out3), 32'hA);
    in_data   = 4'h5;
    in_select = 2'd2;
    #1;
    chk("blk.stall2", 32'(in_ready), 32'h0);
    out_ready = 4'b1111;
    #1;
    chk("blk.refill.rdy", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("blk.refill.vld", 32'(out_valid), 32'b0100);
    chk("blk.refill.dat", 32'(out3), 32'h5);
    tick();
    chk("blk.drained", 32'(out_valid), 32'h0);

    // mode switch: rr_ptr starts at 0 again here (8 rr words wrapped twice)
    rr_mode = 1'b1;
    send("ms.rr0", 4'h1, 2'd3, 0);
    send("ms.rr1", 4'h2, 2'd3, 1);
    rr_mode = 1'b0;
    send("ms.sel3", 4'h3, 2'd3, 3);
    send("ms.sel3b", 4'h4, 2'd3, 3);
    send("ms.sel0", 4'h5, 2'd0, 0);
    rr_mode = 1'b1;
    send("ms.rr2", 4'h6, 2'd0, 2);
    tick();

    // asynchronous reset with slot 2 full (rr_ptr now 3)
    rr_mode   = 1'b0;
    out_ready = 4'b1011;
    send("ar.fill", 4'hC, 2'd2, 2);
    rst_n = 1'b0;
    #1;
    chk("ar.vld", 32'(out_valid), 32'h0);
    chk("ar.out3", 32'(out3), 32'h0);
    #1;
    rst_n     = 1'b1;
    out_ready = 4'b1111;
    tick();
    rr_mode = 1'b1;
    send("ar.ptr", 4'h9, 2'd3, 0);
    tick();

    // random stress
    for (int k = 0; k < 4; k++) begin
      mv[k] = 1'b0;
      md[k] = 4'h0;
    end
    mptr    = 2'd1;
    pending = 1'b0;
    n_in    = 0;
    n_out   = 0;
    for (int c = 0; c < 2000; c++) stress_cycle(1'b1);
    for (int c = 0; c < 3; c++) stress_cycle(1'b0);
    chk("stress.empty", 32'(out_valid), 32'h0);
    chk("stress.count", 32'(n_out), 32'(n_in));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
